// File: rtl/can_pkg.sv
// Shared CAN CRC definitions used by the receive checker and the transmit generator.
package can_pkg;
  localparam int          CAN_CRC_W      = 15;
  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
  localparam int          CAN_STUFF_RUN  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRCF = 2'd2,
    DONE = 2'd3
  } can_crc_state_t;
endpackage

// File: rtl/can_crc15_step.sv
// One serial CAN CRC-15 step: folds one bus bit into the running remainder.
// Purely combinational; shared with the transmit-side CRC generator.
module can_crc15_step
  import can_pkg::*;
(
  input  logic [CAN_CRC_W-1:0] i_crc,
  input  logic                 i_bit,
  output logic [CAN_CRC_W-1:0] o_crc
);
  logic w_nxt;

  assign w_nxt = i_bit ^ i_crc[CAN_CRC_W-1];
  assign o_crc = {i_crc[CAN_CRC_W-2:0], 1'b0} ^ (w_nxt ? CAN_CRC15_POLY : '0);
endmodule

// File: rtl/can_crc_checker.sv
// Receive CRC-15 checker: one bit per valid beat, done pulses the cycle after the last CRC bit; stalls on bit_valid low.
// Define CAN_DESTUFF_EN to remove stuff bits in-line and flag stuff-rule violations.
module can_crc_checker
  import can_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sof,
  input  logic [LEN_W-1:0]     i_len_bits,
  input  logic                 i_bit_in,
  input  logic                 i_bit_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_crc_ok,
  output logic                 o_crc_err,
  output logic                 o_stuff_err,
  output logic [CAN_CRC_W-1:0] o_crc_calc
);
  can_crc_state_t        r_state, w_state_nxt;
  logic [LEN_W-1:0]      r_remain;
  logic [3:0]            r_crcf_cnt;
  logic [CAN_CRC_W-1:0]  r_crc, r_rx_crc, w_crc_step, w_rx_nxt;
  logic                  r_crc_ok, r_crc_err;
  logic                  w_active, w_bit_acc, w_take, w_stuff_bad;

  can_crc15_step u_step (
    .i_crc (r_crc),
    .i_bit (i_bit_in),
    .o_crc (w_crc_step)
  );

  // sof always wins over a bit arriving in the same cycle
  assign w_active  = (r_state == DATA) || (r_state == CRCF);
  assign w_bit_acc = i_bit_valid && w_active && !i_sof;
  assign w_rx_nxt  = {r_rx_crc[CAN_CRC_W-2:0], i_bit_in};

`ifdef CAN_DESTUFF_EN
  logic [2:0] r_run;
  logic       r_last;
  logic       r_stuff_err;
  logic       w_stuff_pos;

  assign w_stuff_pos = (r_run == 3'(CAN_STUFF_RUN));
  assign w_take      = w_bit_acc && !w_stuff_pos;
  assign w_stuff_bad = w_bit_acc && w_stuff_pos && (i_bit_in == r_last);
  assign o_stuff_err = r_stuff_err;

  // A stuff bit of the opposite polarity is swallowed and starts a new run of one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run       <= '0;
      r_last      <= 1'b0;
      r_stuff_err <= 1'b0;
    end else if (i_sof) begin
      r_run       <= '0;
      r_last      <= 1'b0;
      r_stuff_err <= 1'b0;
    end else if (w_bit_acc) begin
      if (w_stuff_bad)
        r_stuff_err <= 1'b1;
      else if (w_stuff_pos || (r_run == '0) || (i_bit_in != r_last))
        r_run <= 3'd1;
      else
        r_run <= r_run + 3'd1;
      r_last <= i_bit_in;
    end
  end
`else
  assign w_take      = w_bit_acc;
  assign w_stuff_bad = 1'b0;
  assign o_stuff_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_sof) begin
      w_state_nxt = (i_len_bits == '0) ? CRCF : DATA;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = IDLE;
        DATA: begin
          if (w_stuff_bad)
            w_state_nxt = DONE;
          else if (w_take && (r_remain == LEN_W'(1)))
            w_state_nxt = CRCF;
        end
        CRCF: begin
          if (w_stuff_bad || (w_take && (r_crcf_cnt == 4'd14)))
            w_state_nxt = DONE;
        end
        DONE: w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      DATA, CRCF: o_busy = 1'b1;
      DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: o_busy = 1'b0;
    endcase
  end

  // r_crc stops updating once DATA is left, so it doubles as the frozen crc_calc.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_remain   <= '0;
      r_crcf_cnt <= '0;
      r_crc      <= '0;
      r_rx_crc   <= '0;
      r_crc_ok   <= 1'b0;
      r_crc_err  <= 1'b0;
    end else if (i_sof) begin
      r_remain   <= i_len_bits;
      r_crcf_cnt <= '0;
      r_crc      <= '0;
      r_rx_crc   <= '0;
      r_crc_ok   <= 1'b0;
      r_crc_err  <= 1'b0;
    end else if (w_take) begin
      if (r_state == DATA) begin
        r_crc    <= w_crc_step;
        r_remain <= r_remain - LEN_W'(1);
      end else begin
        r_rx_crc   <= w_rx_nxt;
        r_crcf_cnt <= r_crcf_cnt + 4'd1;
        if (r_crcf_cnt == 4'd14) begin
          r_crc_ok  <= (w_rx_nxt == r_crc);
          r_crc_err <= (w_rx_nxt != r_crc);
        end
      end
    end
  end

  assign o_crc_ok   = r_crc_ok;
  assign o_crc_err  = r_crc_err;
  assign o_crc_calc = r_crc;
endmodule

// File: tb/tb_can_crc_checker.sv
// Directed bench for can_crc_checker: vector table plus abort, reset and stuffing sequences.
module tb_can_crc_checker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sof = 1'b0;
  logic [15:0] len_bits = '0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        busy, done, crc_ok, crc_err, stuff_err;
  logic [14:0] crc_calc;

  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   tb_run = 0;
  logic tb_last = 1'b0;
  int   gap = 0;

  typedef struct {
    int          len;
    logic [15:0] data;
    logic [14:0] rx;
    int          gap;
    logic [14:0] calc;
    logic        ok;
  } vec_t;

  vec_t v[7];

  always #5 clk = ~clk;

  can_crc_checker #(.LEN_W(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sof       (sof),
    .i_len_bits  (len_bits),
    .i_bit_in    (bit_in),
    .i_bit_valid (bit_valid),
    .o_busy      (busy),
    .o_done      (done),
    .o_crc_ok    (crc_ok),
    .o_crc_err   (crc_err),
    .o_stuff_err (stuff_err),
    .o_crc_calc  (crc_calc)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raw_bit(input logic b);
    repeat (gap) tick();
    bit_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    if (tb_run == 0 || b != tb_last) tb_run = 1;
    else tb_run++;
    tb_last = b;
  endtask

  task automatic send_bit(input logic b);
`ifdef CAN_DESTUFF_EN
    if (tb_run == 5) raw_bit(!tb_last);
`endif
    raw_bit(b);
  endtask

  task automatic send_crc(input logic [14:0] c);
    for (int i = 14; i >= 0; i--) send_bit(c[i]);
  endtask

  task automatic start(input logic [15:0] len);
    sof = 1'b1;
    len_bits = len;
    tick();
    sof = 1'b0;
    tb_run = 0;
  endtask

  initial begin
    int d0;
    v[0] = '{len: 1, data: 16'h0001, rx: 15'h4599, gap: 0, calc: 15'h4599, ok: 1'b1};
    v[1] = '{len: 2, data: 16'h0002, rx: 15'h4EAB, gap: 0, calc: 15'h4EAB, ok: 1'b1};
    v[2] = '{len: 2, data: 16'h0002, rx: 15'h4EAA, gap: 0, calc: 15'h4EAB, ok: 1'b0};
    v[3] = '{len: 0, data: 16'h0000, rx: 15'h0000, gap: 0, calc: 15'h0000, ok: 1'b1};
    v[4] = '{len: 3, data: 16'h0006, rx: 15'h1664, gap: 0, calc: 15'h1664, ok: 1'b1};
    v[5] = '{len: 0, data: 16'h0000, rx: 15'h0000, gap: 3, calc: 15'h0000, ok: 1'b1};
    v[6] = '{len: 1, data: 16'h0001, rx: 15'h0000, gap: 0, calc: 15'h4599, ok: 1'b0};

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ok", crc_ok, 0);
    check("rst_err", crc_err, 0);
    check("rst_stuff", stuff_err, 0);
    check("rst_calc", crc_calc, 0);
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    for (int k = 0; k < 7; k++) begin
      d0 = done_cnt;
      gap = v[k].gap;
      start(v[k].len[15:0]);
      check($sformatf("v%0d_busy", k), busy, 1);
      check($sformatf("v%0d_clr_ok", k), crc_ok, 0);
      check($sformatf("v%0d_clr_calc", k), crc_calc, 0);
      for (int i = v[k].len - 1; i >= 0; i--) send_bit(v[k].data[i]);
      send_crc(v[k].rx);
      gap = 0;
      check($sformatf("v%0d_done", k), done, 1);
      check($sformatf("v%0d_calc", k), crc_calc, v[k].calc);
      check($sformatf("v%0d_ok", k), crc_ok, v[k].ok);
      check($sformatf("v%0d_err", k), crc_err, !v[k].ok);
      check($sformatf("v%0d_stuff", k), stuff_err, 0);
      tick();
      check($sformatf("v%0d_done_drop", k), done, 0);
      check($sformatf("v%0d_idle", k), busy, 0);
      check($sformatf("v%0d_ok_hold", k), crc_ok, v[k].ok);
      check($sformatf("v%0d_done_cnt", k), done_cnt - d0, 1);
    end

    // sof with a coincident bit: the bit must be dropped
    sof = 1'b1; len_bits = 16'd1; bit_in = 1'b1; bit_valid = 1'b1;
    tick();
    sof = 1'b0; bit_valid = 1'b0; tb_run = 0;
    send_bit(1'b1);
    send_crc(15'h4599);
    check("sofbit_done", done, 1);
    check("sofbit_ok", crc_ok, 1);
    check("sofbit_calc", crc_calc, 15'h4599);
    tick();

    // bits while idle are ignored
    bit_in = 1'b0; bit_valid = 1'b1;
    repeat (3) tick();
    bit_valid = 1'b0;
    check("idlebit_busy", busy, 0);
    check("idlebit_ok", crc_ok, 1);
    check("idlebit_calc", crc_calc, 15'h4599);

    // abort after 7 data bits, then a clean frame
    d0 = done_cnt;
    start(16'd20);
    for (int i = 0; i < 7; i++) send_bit(i[0] == 1'b0);
    start(16'd1);
    check("abort_busy", busy, 1);
    check("abort_calc", crc_calc, 0);
    send_bit(1'b1);
    send_crc(15'h4599);
    check("abort_ok", crc_ok, 1);
    tick();
    check("abort_done_cnt", done_cnt - d0, 1);

    // async reset in the middle of the CRC field
    d0 = done_cnt;
    start(16'd1);
    send_bit(1'b1);
    for (int i = 14; i >= 10; i--) send_bit(1'(15'h4599 >> i));
    check("prerst_calc", crc_calc, 15'h4599);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_calc", crc_calc, 0);
    check("midrst_ok", crc_ok, 0);
    check("midrst_err", crc_err, 0);
    repeat (3) tick();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle", busy, 0);

`ifdef CAN_DESTUFF_EN
    start(16'd5);
    for (int i = 0; i < 5; i++) raw_bit(1'b0);
    raw_bit(1'b1);
    send_crc(15'h0000);
    check("dstf_done", done, 1);
    check("dstf_ok", crc_ok, 1);
    check("dstf_stuff", stuff_err, 0);
    tick();
    d0 = done_cnt;
    start(16'd5);
    for (int i = 0; i < 6; i++) raw_bit(1'b0);
    check("stferr_done", done, 1);
    check("stferr_flag", stuff_err, 1);
    check("stferr_ok", crc_ok, 0);
    check("stferr_err", crc_err, 0);
    tick();
    check("stferr_idle", busy, 0);
    check("stferr_hold", stuff_err, 1);
    check("stferr_done_cnt", done_cnt - d0, 1);
`else
    check("nostuff_flag", stuff_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
